// File: rtl/score_formatter.sv
// rtl/score_formatter.sv - percent-correct divider, BCD converter and 7-seg driver
//
// Ports:
//   clk        system clock, all state on rising edge
//   resetn     asynchronous reset, active-high (1 = reset)
//   upd        1-cycle pulse, correct/incorrect valid, start a format pass
//   correct    correct-answer count (clamped to 99)
//   incorrect  incorrect-answer count (clamped to 99)
//   busy       pass in progress
//   done       1-cycle pulse, outputs just updated
//   percent    floor(100*c/(c+i)), 0 when c+i==0
//   hex5,hex4  correct tens/ones, active-low gfedcba
//   hex3,hex2  incorrect tens/ones
//   hex1,hex0  percent tens/ones (display saturates at 99)
module score_formatter #(
  parameter int CNT_W = 7,
  parameter int DIV_W = 14
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             upd,
  input  logic [CNT_W-1:0] correct,
  input  logic [CNT_W-1:0] incorrect,
  output logic             busy,
  output logic             done,
  output logic [6:0]       percent,
  output logic [6:0]       hex5,
  output logic [6:0]       hex4,
  output logic [6:0]       hex3,
  output logic [6:0]       hex2,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0
);

  typedef enum logic [1:0] {IDLE, DIV, BCD, OUT} state_t;

  localparam logic [4:0] DIV_LAST = 5'(DIV_W - 1);

  state_t           state_q, state_d;
  logic             pending_q;
  logic [4:0]       cnt_q;
  logic [2:0]       k_q;
  logic [1:0]       sel_q;
  logic [6:0]       c_q, i_q;
  logic [7:0]       total_q;
  logic [DIV_W-1:0] num_q;
  logic [7:0]       rem_q;
  logic [7:0]       bcd_q;
  logic [6:0]       bin_q;
  logic [7:0]       bcd_c_q, bcd_i_q, bcd_p_q;

  function automatic logic [6:0] clamp99(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(99)) ? 7'd99 : 7'(v);
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] seg_tens(input logic [3:0] d);
    return (d == 4'd0) ? 7'h7F : seg(d);
  endfunction

  // A new pass starts from IDLE on either a fresh upd or one that arrived while busy.
  logic capture;
  assign capture = (state_q == IDLE) && (upd || pending_q);
  assign busy    = (state_q != IDLE);

  // Restoring division step: quotient bits shift into num_q from the LSB, so
  // num_q holds the quotient once all DIV_W steps have run.
  logic [8:0] rem_sh;
  logic [9:0] diff;
  logic       q_bit;
  assign rem_sh = {rem_q, num_q[DIV_W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, total_q};
  assign q_bit  = (total_q != 8'd0) && !diff[9];

  // Double-dabble step; k_q==0 begins a fresh operand with a cleared BCD field.
  logic [6:0] pct_disp, operand, bin_src;
  logic [7:0] bcd_src, adj, bcd_nx;
  assign pct_disp = (num_q[6:0] > 7'd99) ? 7'd99 : num_q[6:0];
  always_comb begin
    operand = pct_disp;
    if (sel_q == 2'd0) operand = c_q;
    else if (sel_q == 2'd1) operand = i_q;
  end
  assign bcd_src   = (k_q == 3'd0) ? 8'd0 : bcd_q;
  assign bin_src   = (k_q == 3'd0) ? operand : bin_q;
  assign adj[3:0]  = (bcd_src[3:0] >= 4'd5) ? bcd_src[3:0] + 4'd3 : bcd_src[3:0];
  assign adj[7:4]  = (bcd_src[7:4] >= 4'd5) ? bcd_src[7:4] + 4'd3 : bcd_src[7:4];
  assign bcd_nx    = {adj[6:0], bin_src[6]};

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture) state_d = DIV;
      DIV:  if (cnt_q == DIV_LAST) state_d = BCD;
      BCD:  if (sel_q == 2'd2 && k_q == 3'd6) state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pending_q <= 1'b0;
      done      <= 1'b0;
      cnt_q     <= '0;
      k_q       <= '0;
      sel_q     <= '0;
      c_q       <= '0;
      i_q       <= '0;
      total_q   <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      bcd_q     <= '0;
      bin_q     <= '0;
      bcd_c_q   <= '0;
      bcd_i_q   <= '0;
      bcd_p_q   <= '0;
      percent   <= '0;
      hex5      <= 7'h7F;
      hex4      <= 7'h40;
      hex3      <= 7'h7F;
      hex2      <= 7'h40;
      hex1      <= 7'h7F;
      hex0      <= 7'h40;
    end else begin
      done <= (state_q == OUT);
      if (upd && state_q != IDLE) pending_q <= 1'b1;
      else if (capture)           pending_q <= 1'b0;

      case (state_q)
        IDLE: if (capture) begin
          c_q     <= clamp99(correct);
          i_q     <= clamp99(incorrect);
          total_q <= {1'b0, clamp99(correct)} + {1'b0, clamp99(incorrect)};
          num_q   <= DIV_W'(clamp99(correct)) * DIV_W'(100);
          rem_q   <= '0;
          cnt_q   <= '0;
          k_q     <= '0;
          sel_q   <= '0;
        end
        DIV: begin
          rem_q <= q_bit ? diff[7:0] : rem_sh[7:0];
          num_q <= {num_q[DIV_W-2:0], q_bit};
          cnt_q <= cnt_q + 5'd1;
        end
        BCD: begin
          bcd_q <= bcd_nx;
          bin_q <= {bin_src[5:0], 1'b0};
          if (k_q == 3'd6) begin
            k_q   <= '0;
            sel_q <= sel_q + 2'd1;
            case (sel_q)
              2'd0:    bcd_c_q <= bcd_nx;
              2'd1:    bcd_i_q <= bcd_nx;
              default: bcd_p_q <= bcd_nx;
            endcase
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        OUT: begin
          percent <= num_q[6:0];
          hex5    <= seg_tens(bcd_c_q[7:4]);
          hex4    <= seg(bcd_c_q[3:0]);
          hex3    <= seg_tens(bcd_i_q[7:4]);
          hex2    <= seg(bcd_i_q[3:0]);
          hex1    <= seg_tens(bcd_p_q[7:4]);
          hex0    <= seg(bcd_p_q[3:0]);
        end
        default: ;
      endcase
    end
  end

endmodule
